// File: rtl/unsigned_divider_seq_if.sv
// Operand/result bundle for the sequential unsigned divider.
// The master issues divisions; the slave (the divider) returns results and status.
interface unsigned_divider_seq_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/unsigned_divider_seq.sv
// Restoring shift-subtract unsigned divider: one quotient bit per clock, MSB first.
// Divide-by-zero short-circuits straight to the result state.
module unsigned_divider_seq #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unsigned_divider_seq_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t       state_reg, state_next;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [N-1:0] work_reg, work_next;
  logic [N-1:0] dvs_reg, dvs_next;
  logic [N-1:0] prem_reg, prem_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [N-1:0] quo_reg, quo_next;
  logic [N-1:0] rem_reg, rem_next;
  logic         dbz_reg, dbz_next;

  logic         accept;
  logic [N:0]   shifted;
  logic [N:0]   diff;
  logic         qbit;

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    dvs_next   = dvs_reg;
    prem_next  = prem_reg;
    cnt_next   = cnt_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;

    accept  = bus.start && (state_reg != CALC);
    shifted = {prem_reg, work_reg[N-1]};
    diff    = shifted - {1'b0, dvs_reg};
    // The partial remainder stays below the divisor, so a set top bit of the
    // difference can only mean a borrow, i.e. shifted < divisor.
    qbit    = ~diff[N];

    case (state_reg)
      IDLE, FIN: begin
        state_next = IDLE;
        if (accept) begin
          if (bus.divisor == '0) begin
            state_next = FIN;
            quo_next   = '1;
            rem_next   = bus.dividend;
            dbz_next   = 1'b1;
          end else begin
            state_next = CALC;
            work_next  = bus.dividend;
            dvs_next   = bus.divisor;
            prem_next  = '0;
            cnt_next   = '0;
          end
        end
      end
      CALC: begin
        prem_next = qbit ? diff[N-1:0] : shifted[N-1:0];
        work_next = {work_reg[N-2:0], qbit};
        cnt_next  = cnt_reg + CW'(1);
        if (cnt_reg == CW'(N - 1)) begin
          state_next = FIN;
          quo_next   = work_next;
          rem_next   = prem_next;
          dbz_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      dvs_reg   <= '0;
      prem_reg  <= '0;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      dvs_reg   <= dvs_next;
      prem_reg  <= prem_next;
      cnt_reg   <= cnt_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
    end
  end

  assign bus.quotient    = quo_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.busy        = (state_reg == CALC);
  assign bus.done        = (state_reg == FIN);
endmodule

// File: tb/tb_unsigned_divider_seq.sv
// Scoreboard bench for unsigned_divider_seq (N=4): expected results queued at
// issue time, popped and compared when done is observed.
module tb_unsigned_divider_seq;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           lat;
    int           busy_n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  int           checks = 0;
  int           passes = 0;
  exp_t         sb[$];
  logic [N-1:0] last_q = '0;
  logic [N-1:0] last_r = '0;

  unsigned_divider_seq_if #(.N(N)) bus ();

  unsigned_divider_seq #(.N(N)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 1; e.busy_n = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = N + 1; e.busy_n = N;
    end
    return e;
  endfunction

  // Drive a request and return just after the edge that samples it.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk);
  endtask

  // Observe cycles after the accepting edge until done, bounded.
  task automatic wait_done(input logic [N-1:0] hq, input logic [N-1:0] hr,
                           output int lat, output int busy_n,
                           output int overlap, output int moved);
    lat = 0; busy_n = 0; overlap = 0; moved = 0;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.quotient !== hq || bus.remainder !== hr) moved++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1; bus.dividend = 4'd7; bus.divisor = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0)
      $display("FAIL reset_state: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b want all 0",
               bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
    else passes++;
    rst_n = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_start_ignored: got busy=%0b done=%0b want 0 0", bus.busy, bus.done);
    else passes++;
    $display("txn reset released");
  endtask

  task automatic test_basic();
    logic [N-1:0] ta [5] = '{4'd13, 4'd2, 4'd0, 4'd7, 4'd15};
    logic [N-1:0] tb [5] = '{4'd3, 4'd9, 4'd5, 4'd0, 4'd1};
    int lat, busy_n, overlap, moved;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      issue(ta[i], tb[i]);
      #1 bus.start = 1'b0;
      wait_done(last_q, last_r, lat, busy_n, overlap, moved);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || busy_n != e.busy_n || overlap != 0 || moved != 0)
        $display("FAIL basic_timing %0d/%0d: got lat=%0d busy=%0d overlap=%0d moved=%0d want lat=%0d busy=%0d",
                 e.a, e.b, lat, busy_n, overlap, moved, e.lat, e.busy_n);
      else passes++;
      checks++;
      if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz)
        $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
                 e.a, e.b, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
      else passes++;
      last_q = e.q; last_r = e.r;
      $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b lat=%0d", e.a, e.b,
               bus.quotient, bus.remainder, bus.div_by_zero, lat);
    end
  endtask

  task automatic test_start_ignored();
    int lat, busy_n, overlap, moved;
    exp_t e;
    @(negedge clk);
    issue(4'd13, 4'd3);
    #1 bus.dividend = 4'd9; bus.divisor = 4'd2;
    for (int op = 0; op < 2; op++) begin
      wait_done(last_q, last_r, lat, busy_n, overlap, moved);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || busy_n != e.busy_n || overlap != 0 || moved != 0)
        $display("FAIL ignore_timing op%0d: got lat=%0d busy=%0d overlap=%0d moved=%0d want lat=%0d busy=%0d",
                 op, lat, busy_n, overlap, moved, e.lat, e.busy_n);
      else passes++;
      checks++;
      if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz)
        $display("FAIL ignore_result op%0d: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
                 op, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
      else passes++;
      last_q = e.q; last_r = e.r;
      $display("txn %0d/%0d -> q=%0d r=%0d (start held)", e.a, e.b, bus.quotient, bus.remainder);
      if (op == 0) begin
        sb.push_back(model(4'd9, 4'd2));
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_calc();
    int lat, busy_n, overlap, moved, dones;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_q = '0; last_r = '0;
    @(negedge clk);
    checks++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0)
      $display("FAIL calc_reset_state: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b want all 0",
               bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
    else passes++;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++;
    if (dones != 0) $display("FAIL calc_reset_no_done: got %0d done cycles want 0", dones);
    else passes++;
    issue(4'd10, 4'd3);
    #1 bus.start = 1'b0;
    wait_done(last_q, last_r, lat, busy_n, overlap, moved);
    e = sb.pop_front();
    checks++;
    if (lat != e.lat || busy_n != e.busy_n || overlap != 0 || moved != 0)
      $display("FAIL calc_reset_timing: got lat=%0d busy=%0d overlap=%0d moved=%0d want lat=%0d busy=%0d",
               lat, busy_n, overlap, moved, e.lat, e.busy_n);
    else passes++;
    checks++;
    if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz)
      $display("FAIL calc_reset_result: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
               bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    else passes++;
    last_q = e.q; last_r = e.r;
    $display("txn %0d/%0d -> q=%0d r=%0d after reset", e.a, e.b, bus.quotient, bus.remainder);
  endtask

  task automatic test_back_to_back();
    int lat, busy_n, overlap, moved;
    exp_t e;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(N'(a), N'(b));
        wait_done(last_q, last_r, lat, busy_n, overlap, moved);
        e = sb.pop_front();
        checks++;
        if (lat != e.lat || busy_n != e.busy_n || overlap != 0 || moved != 0)
          $display("FAIL sweep_timing %0d/%0d: got lat=%0d busy=%0d overlap=%0d moved=%0d want lat=%0d busy=%0d",
                   e.a, e.b, lat, busy_n, overlap, moved, e.lat, e.busy_n);
        else passes++;
        checks++;
        if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz)
          $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
                   e.a, e.b, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
        else passes++;
        last_q = e.q; last_r = e.r;
        $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0b lat=%0d", e.a, e.b,
                 bus.quotient, bus.remainder, bus.div_by_zero, lat);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_calc();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end
endmodule
